// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Multi-cycle magnitude comparator for unsigned words of 4*NIBBLES bits.
//   The operands are captured on an accepted start.  One nibble pair per
//   cycle, most significant nibble first, goes out on nib_a/nib_b to an
//   external 4-bit comparator.  That comparator returns ceq/clt/cgt in the
//   same cycle, and this block folds the flags into a registered word result.
//
//   Optional build macro: SWC_FIXED_LATENCY_EN
//     undefined : the scan stops at the first mismatching nibble.
//     defined   : the scan always covers all NIBBLES nibbles and the first
//                 mismatch fixes the result, so timing does not depend on data.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          comparison request, sampled only while idle
//   word_a/word_b  operands, captured on an accepted start
//   nib_a/nib_b    nibble pair driven to the 4-bit comparator (0 when not comparing)
//   ceq/clt/cgt    flags returned by the 4-bit comparator
//   busy           high while a comparison is running or completing
//   done           one-cycle pulse, result valid
//   eq/lt/gt       registered word result, held until the next accepted start

module serial_word_comparator #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] word_a,
  input  logic [4*NIBBLES-1:0] word_b,
  output logic [3:0]           nib_a,
  output logic [3:0]           nib_b,
  input  logic                 ceq,
  input  logic                 clt,
  input  logic                 cgt,
  output logic                 busy,
  output logic                 done,
  output logic                 eq,
  output logic                 lt,
  output logic                 gt
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic            gt_q, gt_d;
`ifdef SWC_FIXED_LATENCY_EN
  logic            decided_q, decided_d;
`endif

  logic [3:0]      sel_a, sel_b;
  logic            mismatch;

  // Nibble select from the registered index. {idx,2'b00} equals 4*idx.
  assign sel_a = a_q[{idx_q, 2'b00} +: 4];
  assign sel_b = b_q[{idx_q, 2'b00} +: 4];

  // clt takes priority over cgt.  With both low the nibble counts as equal,
  // and this includes the faulty case where all three flags are 0.
  assign mismatch = clt | cgt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
`ifdef SWC_FIXED_LATENCY_EN
    decided_d = decided_q;
`endif
    nib_a   = '0;
    nib_b   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = word_a;
          b_d     = word_b;
          idx_d   = IDX_TOP;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
`ifdef SWC_FIXED_LATENCY_EN
          decided_d = 1'b0;
`endif
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        nib_a = sel_a;
        nib_b = sel_b;
`ifdef SWC_FIXED_LATENCY_EN
        // The first mismatch decides the result. Later nibbles are still
        // presented, but they cannot change it.
        if (!decided_q && mismatch) begin
          lt_d      = clt;
          gt_d      = ~clt;
          decided_d = 1'b1;
        end
        if (idx_q == '0) begin
          if (!decided_q && !mismatch) begin
            eq_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        if (clt) begin
          lt_d    = 1'b1;
          state_d = S_DONE;
        end else if (cgt) begin
          gt_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
`ifdef SWC_FIXED_LATENCY_EN
      decided_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
`ifdef SWC_FIXED_LATENCY_EN
      decided_q <= decided_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule
